snd_mix_mac: RTL and testbench
==============================

Name: snd_mix_mac

Overview:
- Parametrised stereo sound mixer for the sound boards; successor to the fixed-weight inline mixer.
- Sums NCH signed channel sources (FM L/R, speech, PCM voices) into one stereo output pair.
- Each channel has independent run-time-writable L and R gains.
- One time-multiplexed multiplier and MAC sequencer; saturating output; sample-valid handshake.

Parameters:
NCH, 4, number of input channels (2..16)
IW, 16, input sample width, signed
GW, 8, gain width, signed two's complement
FRAC, 6, gain fractional bits; unity = 2^FRAC
OW, 16, output sample width, signed

Ports:
i_EMU_MCLK  in  1  master clock, all logic on rising edge
i_EMU_INITRST_n  in  1  asynchronous active-low reset
i_SAMPLE_STB  in  1  one-cycle request to mix the current inputs
i_CH_DATA  in  NCH*IW  channel samples, ch k at [k*IW +: IW]
i_GAIN_WR  in  1  gain write strobe
i_GAIN_SEL  in  clog2(NCH)+1  {channel, side}; side bit0: 0=L, 1=R
i_GAIN_DATA  in  GW  signed gain value
i_OVR_CLR  in  1  clears o_OVERRUN
o_SND_L  out  OW  mixed left sample
o_SND_R  out  OW  mixed right sample
o_SAMPLE_VALID  out  1  one-cycle pulse when o_SND_L/R update
o_CLIP  out  1  high with o_SAMPLE_VALID if either side saturated
o_BUSY  out  1  high while not IDLE
o_OVERRUN  out  1  sticky: strobe arrived while busy

Behaviour:
- Reset:
  - o_SND_L/R = 0; VALID, CLIP, OVERRUN = 0.
  - State IDLE.
  - All shadow and active gains = 2^FRAC (64 at defaults).
  - Accumulators and input snapshot = 0.
- Gain writes:
  - i_GAIN_WR writes i_GAIN_DATA into shadow gain [i_GAIN_SEL], any state.
  - Out-of-range SEL (channel >= NCH) is ignored.
- States IDLE, MAC, OUT.
- IDLE:
  - On i_SAMPLE_STB, in the same edge: snapshot i_CH_DATA, copy all shadow gains to active gains, clear accL/accR, idx = 0 -> MAC.
  - A gain write in that same cycle lands in shadow only and takes effect on the next sample.
- MAC, one product per edge:
  - prod = snap[idx>>1] * active_gain[idx].
  - idx[0]=0 adds prod to accL; idx[0]=1 adds prod to accR.
  - idx increments; after idx = 2*NCH-1 -> OUT.
  - Multiplier is full signed IW x GW.
  - Accumulators are IW+GW+clog2(NCH)+1 bits and never wrap.
- OUT:
  - Each acc is arithmetic-shifted right by FRAC (floor toward -inf).
  - Result saturates to [-2^(OW-1), 2^(OW-1)-1] and registers to o_SND_L/R.
  - o_SAMPLE_VALID = 1 for exactly one cycle.
  - o_CLIP = 1 in that cycle if either side clamped.
  - -> IDLE.
- Latency:
  - Strobe sampled on edge T; outputs and VALID asserted after edge T+2*NCH+1 (T+9 at defaults).
  - Minimum strobe spacing 2*NCH+2 cycles.
- Strobes outside IDLE (MAC or OUT):
  - Ignored; no effect on the sequence in progress.
  - Set o_OVERRUN.
- o_OVERRUN:
  - Cleared by i_OVR_CLR.
  - Set has priority over clear in the same cycle.
- Between VALID pulses, o_SND_L/R hold their last value.
- o_BUSY = (state != IDLE).
- Asynchronous reset mid-MAC aborts immediately; no VALID is issued.

Optional Feature:
SND_MIX_DCBLOCK_EN
- Defined:
  - A per-side first-order DC blocker is inserted after saturation: y = x - x_prev + y_prev - (y_prev >>> 8).
  - Internal state is OW+8 bits; the result re-saturates to OW.
  - It runs in the OUT cycle, so latency is unchanged.
  - x_prev and y_prev reset to 0.
  - o_CLIP also reports the second saturation.
- Undefined: outputs are the saturated sums directly; no filter state exists.

Test Plan:
- Reset with all inputs at 0 -> o_SND_L = o_SND_R = 0; VALID, CLIP, OVERRUN, BUSY = 0.
- Defaults, ch0 = 1000, others 0, strobe -> exactly 9 cycles later VALID pulses once; L = R = 1000; CLIP = 0.
- Write L gain of ch1 = -32 (SEL = 2), ch1 = 2000, ch2 = -300, strobe -> L = -1300, R = 1700.
- Saturation, all four channels at 30000 unity -> L = R = 32767, CLIP = 1. All four at -30000 -> L = R = -32768, CLIP = 1.
- Second strobe 3 cycles after the first -> OVERRUN = 1; first result unaffected; no second VALID. i_OVR_CLR -> OVERRUN = 0.
- Write ch0 L gain = 0 during MAC of a sample with ch0 = 500 -> that sample L = 500; next sample L = 0.

Source files
------------

// File: rtl/snd_mix_mac.sv
// Stereo mixer: NCH signed sources, per-channel L/R gains, one shared multiplier.
// Define SND_MIX_DCBLOCK_EN to add a per-side DC blocker after output saturation.
module snd_mix_mac #(
  parameter int NCH  = 4,
  parameter int IW   = 16,
  parameter int GW   = 8,
  parameter int FRAC = 6,
  parameter int OW   = 16
) (
  input  logic                       i_EMU_MCLK,
  input  logic                       i_EMU_INITRST_n,
  input  logic                       i_SAMPLE_STB,
  input  logic [NCH*IW-1:0]          i_CH_DATA,
  input  logic                       i_GAIN_WR,
  input  logic [$clog2(NCH):0]       i_GAIN_SEL,
  input  logic [GW-1:0]              i_GAIN_DATA,
  input  logic                       i_OVR_CLR,
  output logic [OW-1:0]              o_SND_L,
  output logic [OW-1:0]              o_SND_R,
  output logic                       o_SAMPLE_VALID,
  output logic                       o_CLIP,
  output logic                       o_BUSY,
  output logic                       o_OVERRUN
);
  localparam int CW = $clog2(NCH);
  localparam int SW = CW + 1;
  localparam int NG = 2 * NCH;
  localparam int PW = IW + GW;
  localparam int AW = IW + GW + CW + 1;
  localparam logic [GW-1:0] UNITY = GW'(2 ** FRAC);
  localparam logic signed [AW-1:0] OMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] OMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;
  state_t r_state, w_next;

  logic [SW-1:0]             r_idx;
  logic [NG-1:0][GW-1:0]     r_gain_sh, r_gain_act;
  logic [NCH-1:0][IW-1:0]    r_snap;
  logic [1:0][AW-1:0]        r_acc;
  logic [OW-1:0]             r_snd_l, r_snd_r;
  logic                      r_valid, r_clip, r_ovr;

  logic signed [IW-1:0]      w_smp;
  logic signed [GW-1:0]      w_g;
  logic signed [PW-1:0]      w_smp_x, w_g_x, w_prod;
  logic [AW-1:0]             w_prod_x;
  logic [1:0][OW-1:0]        w_res;
  logic [1:0]                w_clp;
  logic                      w_sel_ok;

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n)
    if (!i_EMU_INITRST_n) r_state <= S_IDLE;
    else                  r_state <= w_next;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_SAMPLE_STB) w_next = S_MAC;
      S_MAC:   if (r_idx == SW'(NG - 1)) w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operands are sign-extended to the full product width before multiplying.
  assign w_smp    = r_snap[r_idx[SW-1:1]];
  assign w_g      = r_gain_act[r_idx];
  assign w_smp_x  = {{GW{w_smp[IW-1]}}, w_smp};
  assign w_g_x    = {{IW{w_g[GW-1]}}, w_g};
  assign w_prod   = w_smp_x * w_g_x;
  assign w_prod_x = {{(AW-PW){w_prod[PW-1]}}, w_prod};
  assign w_sel_ok = int'(i_GAIN_SEL[SW-1:1]) < NCH;

  for (genvar s = 0; s < 2; s++) begin : g_side
    logic signed [AW-1:0] w_shr;
    logic                 w_hi, w_lo;
    logic [OW-1:0]        w_sat;
    assign w_shr = $signed(r_acc[s]) >>> FRAC;
    assign w_hi  = w_shr > OMAX;
    assign w_lo  = w_shr < OMIN;
    assign w_sat = w_hi ? OMAX[OW-1:0] : (w_lo ? OMIN[OW-1:0] : w_shr[OW-1:0]);
`ifdef SND_MIX_DCBLOCK_EN
    localparam int DW = OW + 10;
    localparam logic signed [DW-1:0] YMAX = {{11{1'b0}}, {(OW+7){1'b1}}};
    localparam logic signed [DW-1:0] YMIN = {{11{1'b1}}, {(OW+7){1'b0}}};
    localparam logic signed [DW-1:0] QMAX = {{11{1'b0}}, {(OW-1){1'b1}}} >>> 8;
    logic [OW-1:0]          r_xp;
    logic [OW+7:0]          r_yp;
    logic signed [OW+7:0]   w_yd;
    logic signed [DW-1:0]   w_y, w_ysat;
    logic                   w_qhi, w_qlo;
    assign w_yd   = $signed(r_yp) >>> 8;
    assign w_y    = $signed({{10{w_sat[OW-1]}}, w_sat}) - $signed({{10{r_xp[OW-1]}}, r_xp})
                  + $signed({{2{r_yp[OW+7]}}, r_yp}) - $signed({{2{w_yd[OW+7]}}, w_yd});
    assign w_ysat = (w_y > YMAX) ? YMAX : ((w_y < YMIN) ? YMIN : w_y);
    assign w_qhi  = w_ysat > $signed({{10{1'b0}}, OMAX[OW-1:0]});
    assign w_qlo  = w_ysat < $signed({{10{1'b1}}, OMIN[OW-1:0]});
    assign w_res[s] = w_qhi ? OMAX[OW-1:0] : (w_qlo ? OMIN[OW-1:0] : w_ysat[OW-1:0]);
    assign w_clp[s] = w_hi | w_lo | w_qhi | w_qlo;
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n)
      if (!i_EMU_INITRST_n) begin
        r_xp <= '0;
        r_yp <= '0;
      end else if (r_state == S_OUT) begin
        r_xp <= w_sat;
        r_yp <= w_ysat[OW+7:0];
      end
    logic w_unused_q;
    assign w_unused_q = |QMAX;
`else
    assign w_res[s] = w_sat;
    assign w_clp[s] = w_hi | w_lo;
`endif
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n)
    if (!i_EMU_INITRST_n) begin
      r_idx      <= '0;
      r_gain_sh  <= {NG{UNITY}};
      r_gain_act <= {NG{UNITY}};
      r_snap     <= '0;
      r_acc      <= '0;
      r_snd_l    <= '0;
      r_snd_r    <= '0;
      r_valid    <= 1'b0;
      r_clip     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_clip  <= 1'b0;
      // Writes only touch the shadow bank; the active bank latches on the strobe.
      if (i_GAIN_WR && w_sel_ok) r_gain_sh[i_GAIN_SEL] <= i_GAIN_DATA;
      if (i_SAMPLE_STB && r_state != S_IDLE) r_ovr <= 1'b1;
      else if (i_OVR_CLR)                     r_ovr <= 1'b0;
      unique case (r_state)
        S_IDLE: if (i_SAMPLE_STB) begin
          r_snap     <= i_CH_DATA;
          r_gain_act <= r_gain_sh;
          r_acc      <= '0;
          r_idx      <= '0;
        end
        S_MAC: begin
          r_acc[r_idx[0]] <= r_acc[r_idx[0]] + w_prod_x;
          r_idx           <= r_idx + SW'(1);
        end
        S_OUT: begin
          r_snd_l <= w_res[0];
          r_snd_r <= w_res[1];
          r_valid <= 1'b1;
          r_clip  <= |w_clp;
        end
        default: ;
      endcase
    end

  assign o_SND_L        = r_snd_l;
  assign o_SND_R        = r_snd_r;
  assign o_SAMPLE_VALID = r_valid;
  assign o_CLIP         = r_clip;
  assign o_BUSY         = (r_state != S_IDLE);
  assign o_OVERRUN      = r_ovr;
endmodule

// File: tb/tb_snd_mix_mac.sv
// Directed bench for snd_mix_mac at default parameters (DC blocker off).
module tb_snd_mix_mac;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic [63:0] ch = '0;
  logic        gwr = 1'b0;
  logic [2:0]  gsel = '0;
  logic [7:0]  gdat = '0;
  logic        oclr = 1'b0;
  logic [15:0] snd_l, snd_r;
  logic        valid, clip, busy, ovr;
  int          n_vec = 0;
  int          n_err = 0;
  int          vcnt, first, rl, rr, rclip, busy0, tmp;

  always #5 clk = ~clk;

  snd_mix_mac dut (
    .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n), .i_SAMPLE_STB(stb),
    .i_CH_DATA(ch), .i_GAIN_WR(gwr), .i_GAIN_SEL(gsel), .i_GAIN_DATA(gdat),
    .i_OVR_CLR(oclr), .o_SND_L(snd_l), .o_SND_R(snd_r),
    .o_SAMPLE_VALID(valid), .o_CLIP(clip), .o_BUSY(busy), .o_OVERRUN(ovr)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int a, input int b, input int c, input int d);
    ch = {16'(d), 16'(c), 16'(b), 16'(a)};
  endtask

  task automatic wr_gain(input int sel, input int val);
    @(negedge clk);
    gwr = 1'b1; gsel = 3'(sel); gdat = 8'(val);
    @(negedge clk);
    gwr = 1'b0;
  endtask

  // Strobe at edge T, then watch 14 edges; optional second strobe / gain write at edge T+k.
  task automatic run(input int stb2, input int gw, input int wsel, input int wval);
    vcnt = 0; first = -1; rl = 0; rr = 0; rclip = 0;
    @(negedge clk);
    stb = 1'b1;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (n == 0) busy0 = int'(busy);
      if (valid === 1'b1) begin
        vcnt++;
        if (first < 0) begin
          first = n; rl = $signed(snd_l); rr = $signed(snd_r); rclip = int'(clip);
        end
      end
      stb  = (stb2 == n + 1);
      gwr  = (gw == n + 1);
      gsel = 3'(wsel); gdat = 8'(wval);
    end
    stb = 1'b0; gwr = 1'b0;
  endtask

  task automatic check_run(input string tag, input int el, input int er, input int ec);
    chk({tag, "_lat"}, first, 9);
    chk({tag, "_npulse"}, vcnt, 1);
    chk({tag, "_L"}, rl, el);
    chk({tag, "_R"}, rr, er);
    chk({tag, "_clip"}, rclip, ec);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_L", $signed(snd_l), 0);
    chk("rst_R", $signed(snd_r), 0);
    chk("rst_valid", valid, 0);
    chk("rst_clip", clip, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    set_ch(1000, 0, 0, 0);
    run(0, 0, 0, 0);
    check_run("unity", 1000, 1000, 0);
    chk("busy_in_mac", busy0, 1);
    repeat (4) @(negedge clk);
    chk("hold_L", $signed(snd_l), 1000);
    chk("hold_valid", valid, 0);

    wr_gain(2, -32);
    set_ch(0, 2000, -300, 0);
    run(0, 0, 0, 0);
    check_run("neg_gain", -1300, 1700, 0);
    wr_gain(2, 64);

    wr_gain(0, 1);
    set_ch(-100, 0, 0, 0);
    run(0, 0, 0, 0);
    check_run("floor", -2, -100, 0);
    wr_gain(0, 64);

    set_ch(30000, 30000, 30000, 30000);
    run(0, 0, 0, 0);
    check_run("sat_pos", 32767, 32767, 1);
    set_ch(-30000, -30000, -30000, -30000);
    run(0, 0, 0, 0);
    check_run("sat_neg", -32768, -32768, 1);

    set_ch(1000, 0, 0, 0);
    chk("ovr_before", ovr, 0);
    run(3, 0, 0, 0);
    check_run("overrun", 1000, 1000, 0);
    chk("ovr_set", ovr, 1);
    @(negedge clk); oclr = 1'b1;
    @(negedge clk); oclr = 1'b0;
    chk("ovr_clr", ovr, 0);

    set_ch(500, 0, 0, 0);
    run(0, 3, 0, 0);
    check_run("gw_mid", 500, 500, 0);
    run(0, 0, 0, 0);
    check_run("gw_next", 0, 500, 0);

    @(negedge clk); stb = 1'b1;
    @(negedge clk); stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_L", $signed(snd_l), 0);
    @(negedge clk); rst_n = 1'b1;
    tmp = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (valid === 1'b1) tmp++;
    end
    chk("abort_novalid", tmp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
